// File: rtl/nts_tx_buffer_if.sv
// nts_tx_buffer_if: write, read and status signals of the NTS transmit packet buffer
interface nts_tx_buffer_if;
  logic        i_clear;
  logic        i_wr_en;
  logic [63:0] i_wr_data;
  logic        i_wr_last;
  logic [7:0]  i_wr_last_valid;
  logic        o_wr_ready;
  logic        o_packet_available;
  logic        o_fifo_empty;
  logic        i_fifo_rd_en;
  logic [63:0] o_fifo_rd_data;
  logic [7:0]  o_data_valid;
  logic        i_packet_read_discard;
  logic        o_busy;
  logic        o_error_overflow;
  logic [31:0] o_tx_packets;
  modport master (
    output i_clear, i_wr_en, i_wr_data, i_wr_last, i_wr_last_valid, i_fifo_rd_en, i_packet_read_discard,
    input  o_wr_ready, o_packet_available, o_fifo_empty, o_fifo_rd_data, o_data_valid, o_busy,
           o_error_overflow, o_tx_packets
  );
  modport slave (
    input  i_clear, i_wr_en, i_wr_data, i_wr_last, i_wr_last_valid, i_fifo_rd_en, i_packet_read_discard,
    output o_wr_ready, o_packet_available, o_fifo_empty, o_fifo_rd_data, o_data_valid, o_busy,
           o_error_overflow, o_tx_packets
  );
endinterface

// File: rtl/nts_tx_buffer.sv
// nts_tx_buffer: single-packet transmit buffer; NTS_TX_PACKET_COUNTER_EN enables the released-packet counter
module nts_tx_buffer #(
  parameter int ADDR_WIDTH = 8
) (
  input logic           i_clk,
  input logic           i_areset,
  nts_tx_buffer_if.slave bus
);
  typedef enum logic [2:0] {EMPTY, WRITE, READY, READ, ERROR_OVERFLOW} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, last_q, last_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]            mask_q, mask_d, dv_q;
  logic                  err_q, err_d;
  logic [63:0]           rd_data_q;
  logic [63:0]           mem_q [2**ADDR_WIDTH];
  logic                  wr_ready, avail, empty, wr_acc, rd_acc, disc_acc;
  assign wr_ready = state_q == EMPTY || state_q == WRITE;
  assign avail    = state_q == READY || state_q == READ;
  assign empty    = !(avail && rd_ptr_q <= {1'b0, last_q});
  assign wr_acc   = bus.i_wr_en && wr_ready && !bus.i_clear;
  assign rd_acc   = bus.i_fifo_rd_en && !empty && !bus.i_clear;
  assign disc_acc = bus.i_packet_read_discard && avail && !bus.i_clear;
  assign bus.o_wr_ready         = wr_ready;
  assign bus.o_packet_available = avail;
  assign bus.o_fifo_empty       = empty;
  assign bus.o_busy             = state_q != EMPTY;
  assign bus.o_error_overflow   = err_q;
  assign bus.o_fifo_rd_data     = rd_data_q;
  assign bus.o_data_valid       = dv_q;
  // Next state and pointer bookkeeping; clear overrides everything else
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    last_d   = last_q;
    mask_d   = mask_q;
    err_d    = err_q;
    case (state_q)
      EMPTY, WRITE: if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        if (bus.i_wr_last) begin
          last_d  = wr_ptr_q;
          mask_d  = bus.i_wr_last_valid;
          state_d = READY;
        end else if (&wr_ptr_q) begin
          state_d = ERROR_OVERFLOW;
          err_d   = 1'b1;
        end else state_d = WRITE;
      end
      READY, READ: if (disc_acc) begin
        state_d  = EMPTY;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
      end else if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + (ADDR_WIDTH+1)'(1);
        state_d  = READ;
      end
      default: ;
    endcase
    if (bus.i_clear) begin
      state_d  = EMPTY;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      err_d    = 1'b0;
    end
  end
  // Control state registers
  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      state_q  <= EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
      mask_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      last_q   <= last_d;
      mask_q   <= mask_d;
      err_q    <= err_d;
    end
  end
  // Packet storage; contents need no reset since pointers gate every read
  always_ff @(posedge i_clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.i_wr_data;
  end
  // Read port: word and mask one cycle after an accepted read, mask zero otherwise
  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      rd_data_q <= '0;
      dv_q      <= '0;
    end else begin
      if (rd_acc) rd_data_q <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
      dv_q <= !rd_acc ? 8'h00 : rd_ptr_q == {1'b0, last_q} ? mask_q : 8'hff;
    end
  end
`ifdef NTS_TX_PACKET_COUNTER_EN
  logic [31:0] tx_cnt_q;
  // Count packets released by the consumer
  always_ff @(posedge i_clk) begin
    if (i_areset) tx_cnt_q <= '0;
    else if (disc_acc) tx_cnt_q <= tx_cnt_q + 32'd1;
  end
  assign bus.o_tx_packets = tx_cnt_q;
`else
  assign bus.o_tx_packets = '0;
`endif
endmodule

// File: tb/tb_nts_tx_buffer.sv
// tb_nts_tx_buffer: scoreboard bench for nts_tx_buffer with a packet-level reference model
module tb_nts_tx_buffer;
  localparam int AW  = 2;
  localparam int CAP = 1 << AW;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  nts_tx_buffer_if bus ();
  nts_tx_buffer #(.ADDR_WIDTH(AW)) dut (.i_clk(clk), .i_areset(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [63:0] pkt[$];
  logic [71:0] sb[$];
  logic [7:0]  mask_m;
  bit          have_pkt, ovf_m;
  int          rd_idx, tx_m;
  task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  function automatic logic [31:0] exp_tx();
`ifdef NTS_TX_PACKET_COUNTER_EN
    return 32'(tx_m);
`else
    return 32'd0;
`endif
  endfunction
  // Monitor: every nonzero byte-valid output must match the oldest expected word
  always @(negedge clk) begin
    if (!rst && bus.o_data_valid != 8'h00) begin
      if (sb.size() == 0) check("unexpected_read_data", {56'b0, bus.o_data_valid}, 64'h0);
      else begin
        logic [71:0] e;
        e = sb.pop_front();
        check("rd_data", bus.o_fifo_rd_data, e[71:8]);
        check("data_valid", {56'b0, bus.o_data_valid}, {56'b0, e[7:0]});
      end
    end
  end
  task automatic model_clear();
    pkt.delete();
    have_pkt = 0;
    ovf_m    = 0;
    rd_idx   = 0;
  endtask
  task automatic chk_status();
    check("wr_ready", {63'b0, bus.o_wr_ready}, {63'b0, !(have_pkt || ovf_m)});
    check("pkt_avail", {63'b0, bus.o_packet_available}, {63'b0, have_pkt});
    check("fifo_empty", {63'b0, bus.o_fifo_empty}, {63'b0, !(have_pkt && rd_idx < pkt.size())});
    check("overflow", {63'b0, bus.o_error_overflow}, {63'b0, ovf_m});
    check("busy", {63'b0, bus.o_busy}, {63'b0, have_pkt || ovf_m || pkt.size() != 0});
    check("tx_packets", {32'b0, bus.o_tx_packets}, {32'b0, exp_tx()});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    chk_status();
  endtask
  task automatic wr(input logic [63:0] d, input bit last, input logic [7:0] m);
    if (!have_pkt && !ovf_m) begin
      pkt.push_back(d);
      if (last) begin
        have_pkt = 1;
        mask_m   = m;
      end else if (pkt.size() == CAP) ovf_m = 1;
    end
    bus.i_wr_en = 1; bus.i_wr_data = d; bus.i_wr_last = last; bus.i_wr_last_valid = m;
    tick();
    bus.i_wr_en = 0; bus.i_wr_last = 0;
  endtask
  task automatic model_read();
    if (have_pkt && rd_idx < pkt.size()) begin
      sb.push_back({pkt[rd_idx], rd_idx == pkt.size() - 1 ? mask_m : 8'hff});
      rd_idx++;
    end
  endtask
  task automatic rd();
    model_read();
    bus.i_fifo_rd_en = 1;
    tick();
    bus.i_fifo_rd_en = 0;
  endtask
  task automatic discard(input bit with_rd);
    if (with_rd) model_read();
    if (have_pkt) begin
      tx_m++;
      model_clear();
    end
    bus.i_packet_read_discard = 1; bus.i_fifo_rd_en = with_rd;
    tick();
    bus.i_packet_read_discard = 0; bus.i_fifo_rd_en = 0;
  endtask
  task automatic clr();
    model_clear();
    bus.i_clear = 1;
    tick();
    bus.i_clear = 0;
  endtask
  task automatic do_reset();
    model_clear();
    tx_m = 0;
    sb.delete();
    rst = 1;
    tick();
    rst = 0;
  endtask
  initial begin
    logic [63:0] last_word;
    bus.i_clear = 0; bus.i_wr_en = 0; bus.i_wr_data = '0; bus.i_wr_last = 0;
    bus.i_wr_last_valid = '0; bus.i_fifo_rd_en = 0; bus.i_packet_read_discard = 0;
    model_clear();
    tx_m = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk_status();
    check("reset_rd_data", bus.o_fifo_rd_data, 64'h0);
    check("reset_dv", {56'b0, bus.o_data_valid}, 64'h0);
    // Three-word packet, last mask f0
    wr(64'hAAAA_0000_0000_0001, 0, 8'h00);
    wr(64'hBBBB_0000_0000_0002, 0, 8'h00);
    wr(64'hCCCC_0000_0000_0003, 1, 8'hf0);
    repeat (3) rd();
    tick();
    discard(0);
    // Single-word packet
    wr(64'h0123_4567_89ab_cdef, 1, 8'h80);
    rd();
    discard(0);
    // Full-capacity packet with last on the final address, then an ignored read
    for (int i = 0; i < CAP; i++) wr(64'h4400 + 64'(i), i == CAP - 1, 8'h3c);
    for (int i = 0; i < CAP; i++) rd();
    last_word = 64'h4400 + 64'(CAP - 1);
    rd();
    tick();
    check("rd_data_hold", bus.o_fifo_rd_data, last_word);
    check("dv_idle", {56'b0, bus.o_data_valid}, 64'h0);
    discard(0);
    // Overflow, ignored discard, then clear
    for (int i = 0; i < CAP; i++) wr(64'h5500 + 64'(i), 0, 8'h00);
    wr(64'hdead, 1, 8'hff);
    discard(0);
    tick();
    clr();
    // Clear during READ after one read
    wr(64'h7701, 0, 8'h00);
    wr(64'h7702, 0, 8'h00);
    wr(64'h7703, 1, 8'hc0);
    rd();
    clr();
    tick();
    // Reset in the middle of a packet
    wr(64'h8801, 0, 8'h00);
    wr(64'h8802, 0, 8'h00);
    do_reset();
    check("midpkt_rd_data", bus.o_fifo_rd_data, 64'h0);
    check("midpkt_dv", {56'b0, bus.o_data_valid}, 64'h0);
    // Randomized packets
    for (int p = 0; p < 60; p++) begin
      int len, nrd;
      bit ovf_pkt;
      logic [7:0] m;
      ovf_pkt = $urandom_range(0, 7) == 0;
      len = ovf_pkt ? CAP : $urandom_range(1, CAP);
      m = 8'($urandom_range(1, 255));
      if ($urandom_range(0, 3) == 0) rd();
      for (int w = 0; w < len; w++) begin
        if ($urandom_range(0, 3) == 0) tick();
        wr({$urandom, $urandom}, !ovf_pkt && w == len - 1, m);
      end
      wr({$urandom, $urandom}, 1, 8'hff);
      if (ovf_pkt) begin
        discard(1);
        clr();
        continue;
      end
      nrd = $urandom_range(0, len + 1);
      for (int r = 0; r < nrd; r++) begin
        if ($urandom_range(0, 2) == 0) tick();
        rd();
      end
      if ($urandom_range(0, 5) == 0) clr();
      else discard(1'($urandom_range(0, 1)));
    end
    repeat (3) tick();
    check("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
